store_buffer: RTL and testbench

Parametrised store unit and write buffer between the core's MEMWRITE path and data memory. Accepts byte, halfword, word (and doubleword when XLEN=64) stores, aligns data onto byte lanes with a write strobe, and queues up to DEPTH stores. Drains them to memory over a req/ack handshake so the control FSM can return to FETCH without waiting on memory. Misaligned or illegal stores raise a registered fault instead of being enqueued. Loads whose word has a pending store are flagged so the core can stall.

---
 rtl/store_buffer.sv | 157 +++++++++++++++
 tb/tb_store_buffer.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/store_buffer.sv
// store_buffer: lane-aligns RISC-V stores and queues them for
// in-order drain to data memory over a req/ack handshake.
module store_buffer #(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     st_valid,
    output logic                     st_ready,
    input  logic [ADDR_W-1:0]        st_addr,
    input  logic [XLEN-1:0]          st_data,
    input  logic [2:0]               st_funct3,
    output logic                     st_fault,
    output logic [ADDR_W-1:0]        st_fault_addr,
    output logic                     mem_req,
    input  logic                     mem_ack,
    output logic [ADDR_W-1:0]        mem_addr,
    output logic [XLEN-1:0]          mem_wdata,
    output logic [XLEN/8-1:0]        mem_wstrb,
    input  logic [ADDR_W-1:0]        ld_addr,
    output logic                     ld_conflict,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty
);
    localparam int LANES = XLEN / 8;
    localparam int OFS_W = $clog2(LANES);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int WA_W  = ADDR_W - OFS_W;

    localparam logic [2:0] F3_SB = 3'b000;
    localparam logic [2:0] F3_SH = 3'b001;
    localparam logic [2:0] F3_SW = 3'b010;
    localparam logic [2:0] F3_SD = 3'b011;

    typedef struct packed {
        logic [WA_W-1:0]  waddr;
        logic [XLEN-1:0]  data;
        logic [LANES-1:0] strb;
    } entry_t;

    entry_t           entries [DEPTH];
    logic [DEPTH-1:0] valid;
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [CNT_W-1:0] count_q;

    logic [OFS_W-1:0] ofs;
    logic             legal;
    logic [XLEN-1:0]  lane_data;
    logic [LANES-1:0] lane_strb;
    logic             full;
    logic             accept;
    logic             push;
    logic             pop;
    entry_t           head_e;
    logic             unused_ld;

    assign ofs = st_addr[OFS_W-1:0];

    // Size/alignment decode; replicated data lets memory pick any lane.
    always_comb begin
        legal     = 1'b0;
        lane_data = st_data;
        lane_strb = '0;
        case (st_funct3)
            F3_SB: begin
                legal     = 1'b1;
                lane_data = {LANES{st_data[7:0]}};
                lane_strb = LANES'(1) << ofs;
            end
            F3_SH: begin
                legal     = ~ofs[0];
                lane_data = {(LANES/2){st_data[15:0]}};
                lane_strb = LANES'(2'b11) << ofs;
            end
            F3_SW: begin
                legal     = (ofs[1:0] == 2'b00);
                lane_data = {(XLEN/32){st_data[31:0]}};
                lane_strb = LANES'(4'hF) << ofs;
            end
            F3_SD: begin
                legal     = (XLEN == 64) && (ofs == '0);
                lane_data = st_data;
                lane_strb = '1;
            end
            default: begin
                legal = 1'b0;
            end
        endcase
    end

    assign full     = (count_q == CNT_W'(DEPTH));
    assign empty    = (count_q == '0);
    assign count    = count_q;
    assign st_ready = !reset && !full;
    assign accept   = st_valid && st_ready;
    assign push     = accept && legal;
    assign pop      = mem_ack && !empty;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head          <= '0;
            tail          <= '0;
            count_q       <= '0;
            valid         <= '0;
            st_fault      <= 1'b0;
            st_fault_addr <= '0;
        end else begin
            if (push) begin
                tail        <= tail + PTR_W'(1);
                valid[tail] <= 1'b1;
            end
            if (pop) begin
                head        <= head + PTR_W'(1);
                valid[head] <= 1'b0;
            end
            count_q  <= count_q + CNT_W'(push) - CNT_W'(pop);
            st_fault <= accept && !legal;
            if (accept && !legal) begin
                st_fault_addr <= st_addr;
            end
        end
    end

    // Payload needs no reset: valid/count gate every use of it.
    always_ff @(posedge clk) begin
        if (push) begin
            entries[tail] <= '{
                waddr: st_addr[ADDR_W-1:OFS_W],
                data:  lane_data,
                strb:  lane_strb
            };
        end
    end

    assign head_e    = entries[head];
    assign mem_req   = !empty;
    assign mem_addr  = {head_e.waddr, {OFS_W{1'b0}}};
    assign mem_wdata = head_e.data;
    assign mem_wstrb = empty ? '0 : head_e.strb;

    // Popping entry still counts; the one being enqueued does not yet.
    always_comb begin
        ld_conflict = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid[i] && entries[i].waddr == ld_addr[ADDR_W-1:OFS_W]) begin
                ld_conflict = 1'b1;
            end
        end
    end

    assign unused_ld = ^ld_addr[OFS_W-1:0];

endmodule

// File: tb/tb_store_buffer.sv
// Testbench for store_buffer: directed steps on XLEN=32 and XLEN=64
// instances, then random traffic against a queue-based reference model.
module tb_store_buffer;
    localparam int DEPTH = 4;

    int checks = 0;
    int passed = 0;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic reset;

    logic        st_valid, st_ready, st_fault, mem_req, mem_ack;
    logic        ld_conflict, empty;
    logic [31:0] st_addr, st_data, st_fault_addr, mem_addr, mem_wdata;
    logic [31:0] ld_addr;
    logic [2:0]  st_funct3, count;
    logic [3:0]  mem_wstrb;

    logic        d_st_valid, d_st_ready, d_st_fault, d_mem_req, d_mem_ack;
    logic        d_ld_conflict, d_empty;
    logic [31:0] d_st_addr, d_st_fault_addr, d_mem_addr, d_ld_addr;
    logic [63:0] d_st_data, d_mem_wdata;
    logic [2:0]  d_st_funct3, d_count;
    logic [7:0]  d_mem_wstrb;

    store_buffer #(.XLEN(32), .ADDR_W(32), .DEPTH(DEPTH)) dut32 (
        .clk(clk), .reset(reset),
        .st_valid(st_valid), .st_ready(st_ready),
        .st_addr(st_addr), .st_data(st_data), .st_funct3(st_funct3),
        .st_fault(st_fault), .st_fault_addr(st_fault_addr),
        .mem_req(mem_req), .mem_ack(mem_ack), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .ld_addr(ld_addr), .ld_conflict(ld_conflict),
        .count(count), .empty(empty)
    );

    store_buffer #(.XLEN(64), .ADDR_W(32), .DEPTH(DEPTH)) dut64 (
        .clk(clk), .reset(reset),
        .st_valid(d_st_valid), .st_ready(d_st_ready),
        .st_addr(d_st_addr), .st_data(d_st_data), .st_funct3(d_st_funct3),
        .st_fault(d_st_fault), .st_fault_addr(d_st_fault_addr),
        .mem_req(d_mem_req), .mem_ack(d_mem_ack), .mem_addr(d_mem_addr),
        .mem_wdata(d_mem_wdata), .mem_wstrb(d_mem_wstrb),
        .ld_addr(d_ld_addr), .ld_conflict(d_ld_conflict),
        .count(d_count), .empty(d_empty)
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
    } ent_t;

    ent_t        q[$];
    logic        m_fault;
    logic [31:0] m_fault_addr;

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic int size_of(input logic [2:0] f3);
        case (f3)
            3'd0: return 1;
            3'd1: return 2;
            3'd2: return 4;
            default: return 0;
        endcase
    endfunction

    function automatic ent_t make_ent(input logic [31:0] a, input logic [31:0] d,
                                      input int sz);
        ent_t e;
        int   o;
        o = int'(a % 4);
        e.addr = a - 32'(o);
        for (int k = 0; k < 4; k++) begin
            e.data[8*k +: 8] = 8'((d >> (8 * (k % sz))) & 32'hFF);
            e.strb[k] = (k >= o) && (k < o + sz);
        end
        return e;
    endfunction

    initial begin
        ent_t        e;
        int          sz;
        bit          lgl;
        bit          hs;
        bit          cf;
        int          r;

        reset = 1'b1;
        st_valid = 0; st_addr = 0; st_data = 0; st_funct3 = 0;
        mem_ack = 0; ld_addr = 0;
        d_st_valid = 0; d_st_addr = 0; d_st_data = 0; d_st_funct3 = 0;
        d_mem_ack = 0; d_ld_addr = 0;
        #1;
        cyc();
        cyc();

        check("rst_ready", st_ready, 0);
        check("rst_req", mem_req, 0);
        check("rst_fault", st_fault, 0);
        check("rst_faddr", st_fault_addr, 0);
        check("rst_count", count, 0);
        check("rst_empty", empty, 1);
        check("rst_wstrb", mem_wstrb, 0);
        check("rst64_req", d_mem_req, 0);
        check("rst64_wstrb", d_mem_wstrb, 0);

        reset = 1'b0;
        #1;
        check("post_rst_ready", st_ready, 1);
        check("post_rst_ready64", d_st_ready, 1);

        // sw 256 at 44, ack held off two cycles
        st_valid = 1; st_addr = 44; st_data = 256; st_funct3 = 3'b010;
        cyc();
        st_valid = 0;
        for (int i = 0; i < 3; i++) begin
            check("sw_req", mem_req, 1);
            check("sw_addr", mem_addr, 44);
            check("sw_wdata", mem_wdata, 32'h100);
            check("sw_wstrb", mem_wstrb, 4'hF);
            check("sw_count", count, 1);
            if (i < 2) cyc();
        end
        mem_ack = 1;
        cyc();
        mem_ack = 0;
        check("sw_count_ack", count, 0);
        check("sw_req_ack", mem_req, 0);

        // sb at 45, then sh at 46 enqueued in the same cycle the sb pops
        st_valid = 1; st_addr = 45; st_data = 32'hAB; st_funct3 = 3'b000;
        cyc();
        st_valid = 0;
        check("sb_addr", mem_addr, 44);
        check("sb_wdata", mem_wdata, 32'hABABABAB);
        check("sb_wstrb", mem_wstrb, 4'b0010);
        st_valid = 1; st_addr = 46; st_data = 32'hBEEF; st_funct3 = 3'b001;
        mem_ack = 1;
        cyc();
        st_valid = 0; mem_ack = 0;
        check("sh_count", count, 1);
        check("sh_addr", mem_addr, 44);
        check("sh_wdata", mem_wdata, 32'hBEEFBEEF);
        check("sh_wstrb", mem_wstrb, 4'b1100);
        mem_ack = 1;
        cyc();
        mem_ack = 0;
        check("sh_empty", empty, 1);

        // back-to-back faults
        st_valid = 1; st_addr = 47; st_funct3 = 3'b001;
        cyc();
        check("f1_fault", st_fault, 1);
        check("f1_faddr", st_fault_addr, 47);
        check("f1_count", count, 0);
        check("f1_req", mem_req, 0);
        st_addr = 48; st_funct3 = 3'b100;
        cyc();
        st_valid = 0;
        check("f2_fault", st_fault, 1);
        check("f2_faddr", st_fault_addr, 48);
        check("f2_count", count, 0);
        check("f2_req", mem_req, 0);
        cyc();
        check("f3_fault", st_fault, 0);
        check("f3_faddr", st_fault_addr, 48);

        // fill, refuse while full even with a pop, then drain in order
        for (int i = 0; i < 4; i++) begin
            st_valid = 1; st_addr = 44 + 4 * i; st_data = i + 1;
            st_funct3 = 3'b010;
            #1;
            check("fill_ready", st_ready, 1);
            cyc();
        end
        st_addr = 60; st_data = 5;
        #1;
        check("full_ready", st_ready, 0);
        check("full_count", count, 4);
        mem_ack = 1;
        #1;
        check("full_head", mem_addr, 44);
        cyc();
        mem_ack = 0;
        #1;
        check("full_pop_count", count, 3);
        check("full_pop_ready", st_ready, 1);
        cyc();
        st_valid = 0;
        check("fifth_count", count, 4);
        for (int i = 0; i < 4; i++) begin
            check("drain_addr", mem_addr, 48 + 4 * i);
            check("drain_data", mem_wdata, i + 2);
            mem_ack = 1;
            cyc();
            mem_ack = 0;
        end
        check("drain_empty", empty, 1);

        // load conflict
        st_valid = 1; st_addr = 48; st_data = 32'h77; st_funct3 = 3'b010;
        ld_addr = 50;
        #1;
        check("ld_enq_excl", ld_conflict, 0);
        cyc();
        st_valid = 0;
        #1;
        check("ld_50", ld_conflict, 1);
        ld_addr = 52;
        #1;
        check("ld_52", ld_conflict, 0);
        ld_addr = 50; mem_ack = 1;
        #1;
        check("ld_pop_incl", ld_conflict, 1);
        cyc();
        mem_ack = 0;
        #1;
        check("ld_after_ack", ld_conflict, 0);

        // XLEN=64: sd, misaligned sd, then reset mid-drain
        d_st_valid = 1; d_st_addr = 8; d_st_funct3 = 3'b011;
        d_st_data = 64'h1122334455667788;
        cyc();
        d_st_valid = 0;
        check("sd_req", d_mem_req, 1);
        check("sd_addr", d_mem_addr, 8);
        check("sd_wstrb", d_mem_wstrb, 8'hFF);
        check("sd_wdata", d_mem_wdata, 64'h1122334455667788);
        d_st_valid = 1; d_st_addr = 12;
        cyc();
        check("sd12_fault", d_st_fault, 1);
        check("sd12_faddr", d_st_fault_addr, 12);
        check("sd12_count", d_count, 1);
        d_st_addr = 17; d_st_funct3 = 3'b000; d_st_data = 64'h5A;
        cyc();
        d_st_addr = 28; d_st_funct3 = 3'b010; d_st_data = 64'hCAFEF00D;
        cyc();
        d_st_valid = 0;
        check("d_count3", d_count, 3);
        reset = 1;
        #1;
        check("d_rst_req", d_mem_req, 0);
        check("d_rst_count", d_count, 0);
        check("d_rst_empty", d_empty, 1);
        check("d_rst_wstrb", d_mem_wstrb, 0);
        check("d_rst_ready", d_st_ready, 0);
        check("d_rst_faddr", d_st_fault_addr, 0);
        cyc();
        reset = 0;
        for (int i = 0; i < 3; i++) begin
            d_mem_ack = 1'(i % 2 == 0);
            cyc();
            check("d_idle_req", d_mem_req, 0);
            check("d_idle_count", d_count, 0);
        end
        d_mem_ack = 0;
        d_st_valid = 1; d_st_addr = 17; d_st_funct3 = 3'b000; d_st_data = 64'h5A;
        cyc();
        check("d_sb_addr", d_mem_addr, 16);
        check("d_sb_wstrb", d_mem_wstrb, 8'h02);
        check("d_sb_wdata", d_mem_wdata, 64'h5A5A5A5A5A5A5A5A);
        d_st_addr = 28; d_st_funct3 = 3'b010; d_st_data = 64'hCAFEF00D;
        d_mem_ack = 1;
        cyc();
        d_st_valid = 0;
        check("d_sw_addr", d_mem_addr, 24);
        check("d_sw_wstrb", d_mem_wstrb, 8'hF0);
        check("d_sw_wdata", d_mem_wdata, 64'hCAFEF00DCAFEF00D);
        cyc();
        d_mem_ack = 0;
        check("d_final_empty", d_empty, 1);

        // random traffic on the 32-bit instance; model starts from reset
        reset = 1;
        cyc();
        reset = 0;
        q.delete();
        m_fault = 0;
        m_fault_addr = 0;
        for (int n = 0; n < 400; n++) begin
            st_valid = ($urandom_range(0, 2) != 0);
            st_addr = 32'h40 + $urandom_range(0, 15);
            st_data = $urandom;
            r = $urandom_range(0, 9);
            st_funct3 = (r < 8) ? 3'(r % 3) : 3'($urandom_range(3, 7));
            mem_ack = ($urandom_range(0, 2) == 0);
            ld_addr = 32'h40 + $urandom_range(0, 19);
            #1;
            check("r_ready", st_ready, q.size() < DEPTH);
            check("r_req", mem_req, q.size() > 0);
            check("r_empty", empty, q.size() == 0);
            check("r_count", count, q.size());
            check("r_fault", st_fault, m_fault);
            check("r_faddr", st_fault_addr, m_fault_addr);
            cf = 0;
            foreach (q[j]) if (q[j].addr == (ld_addr & ~32'h3)) cf = 1;
            check("r_conflict", ld_conflict, cf);
            if (q.size() > 0) begin
                check("r_addr", mem_addr, q[0].addr);
                check("r_wdata", mem_wdata, q[0].data);
                check("r_wstrb", mem_wstrb, q[0].strb);
            end
            sz = size_of(st_funct3);
            lgl = (sz != 0) && (st_addr % sz == 0);
            hs = st_valid && (q.size() < DEPTH);
            if (mem_ack && q.size() > 0) void'(q.pop_front());
            if (hs && lgl) begin
                e = make_ent(st_addr, st_data, sz);
                q.push_back(e);
            end
            m_fault = hs && !lgl;
            if (hs && !lgl) m_fault_addr = st_addr;
            cyc();
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
